// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : ALU decode/sequencing stage. Emits one micro-op per handshake,
//            expands SWAP into three XORs, and consumes HALT/illegal opcodes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package Definitions;
    typedef enum logic [3:0] {
        ADD  = 4'd0,
        LSH  = 4'd1,
        XOR  = 4'd2,
        AND  = 4'd3,
        FLIP = 4'd4,
        CPY  = 4'd5,
        GETB = 4'd6,
        BXOR = 4'd7,
        SETB = 4'd8
    } op_mne;

    typedef enum logic [4:0] {
        ZERO  = 5'd0,
        ONE   = 5'd1,
        TWO   = 5'd2,
        THREE = 5'd3
    } val_mne;
endpackage

module alu_op_sequencer
    import Definitions::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [8:0]  Inst,
    input  logic        InstValid,
    output logic        InstReady,
    output logic [3:0]  OpCode,
    output logic [2:0]  Dst,
    output logic [2:0]  Src,
    output logic [4:0]  ValSel,
    output logic        OpValid,
    input  logic        OpReady,
    output logic        Done,
    output logic        Illegal,
    output logic [15:0] OpCount
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SWAP1  = 2'd1,
        SWAP2  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [3:0] c_opc_last_single = 4'd8;
    localparam logic [3:0] c_opc_swap        = 4'd9;
    localparam logic [3:0] c_opc_halt        = 4'd15;

    state_t      state_q,     state_d;
    op_mne       op_code_q,   op_code_d;
    logic [2:0]  dst_q,       dst_d;
    logic [2:0]  src_q,       src_d;
    val_mne      val_sel_q,   val_sel_d;
    logic        op_valid_q,  op_valid_d;
    logic        illegal_q,   illegal_d;
    logic [15:0] op_count_q,  op_count_d;
    logic [2:0]  swap_rd_q,   swap_rd_d;

    logic        slot_free;
    logic        inst_ready;
    logic        fire;
    logic [3:0]  inst_opc;
    logic [2:0]  inst_rd;
    logic [1:0]  inst_rs;

    assign inst_opc = Inst[8:5];
    assign inst_rd  = Inst[4:2];
    assign inst_rs  = Inst[1:0];

    always_comb begin
        slot_free  = !op_valid_q || OpReady;
        inst_ready = Reset_n && (state_q == RUN) && slot_free;
        fire       = op_valid_q && OpReady;

        state_d    = state_q;
        op_code_d  = op_code_q;
        dst_d      = dst_q;
        src_d      = src_q;
        val_sel_d  = val_sel_q;
        swap_rd_d  = swap_rd_q;
        illegal_d  = illegal_q;
        // A drained op clears the slot unless a new load below refills it.
        op_valid_d = op_valid_q && !OpReady;
        op_count_d = (fire && op_count_q != 16'hFFFF) ? op_count_q + 16'd1 : op_count_q;

        case (state_q)
            RUN: begin
                if (InstValid && inst_ready) begin
                    if (inst_opc <= c_opc_last_single) begin
                        op_code_d  = op_mne'(inst_opc);
                        dst_d      = inst_rd;
                        src_d      = {1'b0, inst_rs};
                        val_sel_d  = val_mne'({3'b000, inst_rs});
                        op_valid_d = 1'b1;
                    end else if (inst_opc == c_opc_swap) begin
                        op_code_d  = XOR;
                        dst_d      = 3'd0;
                        src_d      = inst_rd;
                        val_sel_d  = ZERO;
                        op_valid_d = 1'b1;
                        swap_rd_d  = inst_rd;
                        state_d    = SWAP1;
                    end else if (inst_opc == c_opc_halt) begin
                        state_d    = HALTED;
                    end else begin
                        illegal_d  = 1'b1;
                    end
                end
            end
            SWAP1: begin
                if (slot_free) begin
                    op_code_d  = XOR;
                    dst_d      = swap_rd_q;
                    src_d      = 3'd0;
                    val_sel_d  = ZERO;
                    op_valid_d = 1'b1;
                    state_d    = SWAP2;
                end
            end
            SWAP2: begin
                if (slot_free) begin
                    op_code_d  = XOR;
                    dst_d      = 3'd0;
                    src_d      = swap_rd_q;
                    val_sel_d  = ZERO;
                    op_valid_d = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= RUN;
            op_code_q  <= ADD;
            dst_q      <= 3'd0;
            src_q      <= 3'd0;
            val_sel_q  <= ZERO;
            op_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            op_count_q <= 16'd0;
            swap_rd_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            op_code_q  <= op_code_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            val_sel_q  <= val_sel_d;
            op_valid_q <= op_valid_d;
            illegal_q  <= illegal_d;
            op_count_q <= op_count_d;
            swap_rd_q  <= swap_rd_d;
        end
    end

    assign InstReady = inst_ready;
    assign OpCode    = op_code_q;
    assign Dst       = dst_q;
    assign Src       = src_q;
    assign ValSel    = val_sel_q;
    assign OpValid   = op_valid_q;
    assign Illegal   = illegal_q;
    assign OpCount   = op_count_q;
    assign Done      = (state_q == HALTED) && !op_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed self-checking bench with a micro-op scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

    logic        Clk;
    logic        Reset_n;
    logic [8:0]  Inst;
    logic        InstValid;
    logic        InstReady;
    logic [3:0]  OpCode;
    logic [2:0]  Dst;
    logic [2:0]  Src;
    logic [4:0]  ValSel;
    logic        OpValid;
    logic        OpReady;
    logic        Done;
    logic        Illegal;
    logic [15:0] OpCount;

    int n_checks = 0;
    int n_fail   = 0;
    logic [14:0] sb[$];

    alu_op_sequencer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Inst      (Inst),
        .InstValid (InstValid),
        .InstReady (InstReady),
        .OpCode    (OpCode),
        .Dst       (Dst),
        .Src       (Src),
        .ValSel    (ValSel),
        .OpValid   (OpValid),
        .OpReady   (OpReady),
        .Done      (Done),
        .Illegal   (Illegal),
        .OpCount   (OpCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s, input logic [4:0] v);
        sb.push_back({op, d, s, v});
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Handshake completes on the next rising edge; inputs are stable from here to it.
    always @(negedge Clk) begin
        if (OpValid === 1'b1 && OpReady === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL sb_unexpected_op observed=%0h expected=none", {OpCode, Dst, Src, ValSel});
            end else begin
                chk("sb_op", {17'd0, OpCode, Dst, Src, ValSel}, {17'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        Reset_n   = 1'b0;
        Inst      = 9'd0;
        InstValid = 1'b0;
        OpReady   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_opvalid",  OpValid,   0);
        chk("rst_opcode",   OpCode,    0);
        chk("rst_dst",      Dst,       0);
        chk("rst_src",      Src,       0);
        chk("rst_valsel",   ValSel,    0);
        chk("rst_done",     Done,      0);
        chk("rst_illegal",  Illegal,   0);
        chk("rst_opcount",  OpCount,   0);
        chk("rst_instrdy",  InstReady, 0);
        Reset_n = 1'b1;
        #1;
        chk("post_rst_instrdy", InstReady, 1);

        // Back-to-back stream with OpReady high
        OpReady = 1'b1; InstValid = 1'b1; Inst = 9'b0000_011_10;
        push(4'd0, 3'd3, 3'd2, 5'd2);
        tick();
        chk("s1_opvalid", OpValid, 1);
        chk("s1_opcode",  OpCode,  0);
        chk("s1_dst",     Dst,     3);
        chk("s1_src",     Src,     2);
        chk("s1_valsel",  ValSel,  2);
        Inst = 9'b0010_001_01;
        push(4'd2, 3'd1, 3'd1, 5'd1);
        tick();
        chk("s2_opvalid", OpValid, 1);
        chk("s2_opcode",  OpCode,  2);
        chk("s2_dst",     Dst,     1);
        chk("s2_src",     Src,     1);
        chk("s2_valsel",  ValSel,  1);
        InstValid = 1'b0;
        tick();
        chk("s3_opvalid", OpValid, 0);
        chk("s3_opcount", OpCount, 2);

        // Backpressure holds outputs and count
        OpReady = 1'b0; InstValid = 1'b1; Inst = 9'b0000_011_10;
        push(4'd0, 3'd3, 3'd2, 5'd2);
        tick();
        InstValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_opvalid", OpValid,   1);
            chk("bp_dst",     Dst,       3);
            chk("bp_src",     Src,       2);
            chk("bp_instrdy", InstReady, 0);
            chk("bp_opcount", OpCount,   2);
            tick();
        end
        OpReady = 1'b1;
        #1;
        chk("bp_release_instrdy", InstReady, 1);
        tick();
        chk("bp_opcount_after", OpCount, 3);
        chk("bp_opvalid_after", OpValid, 0);

        // SWAP r5 with OpReady pattern 1,0,1,1
        InstValid = 1'b1; Inst = 9'b1001_101_00;
        push(4'd2, 3'd0, 3'd5, 5'd0);
        push(4'd2, 3'd5, 3'd0, 5'd0);
        push(4'd2, 3'd0, 3'd5, 5'd0);
        tick();
        InstValid = 1'b0;
        chk("sw0_opcode",  OpCode,    2);
        chk("sw0_dst",     Dst,       0);
        chk("sw0_src",     Src,       5);
        chk("sw0_valsel",  ValSel,    0);
        chk("sw0_instrdy", InstReady, 0);
        tick();
        chk("sw1_dst", Dst, 5);
        chk("sw1_src", Src, 0);
        OpReady = 1'b0;
        #1;
        chk("sw1_instrdy", InstReady, 0);
        tick();
        chk("sw1_hold_dst", Dst,     5);
        chk("sw1_hold_vld", OpValid, 1);
        OpReady = 1'b1;
        #1;
        chk("sw2_instrdy", InstReady, 0);
        tick();
        chk("sw2_dst",     Dst,       0);
        chk("sw2_src",     Src,       5);
        chk("sw2_instrdy", InstReady, 1);
        tick();
        chk("sw_opvalid_end", OpValid, 0);
        chk("sw_opcount",     OpCount, 6);

        // Illegal opcode between two ADDs
        InstValid = 1'b1; Inst = 9'b0000_001_00;
        push(4'd0, 3'd1, 3'd0, 5'd0);
        tick();
        Inst = 9'b1100_000_00;
        tick();
        chk("ill_opvalid", OpValid, 0);
        chk("ill_flag",    Illegal, 1);
        Inst = 9'b0000_010_01;
        push(4'd0, 3'd2, 3'd1, 5'd1);
        tick();
        InstValid = 1'b0;
        tick();
        chk("ill_opcount", OpCount, 8);
        repeat (100) tick();
        chk("ill_sticky", Illegal, 1);

        // HALT behind a stalled ADD
        OpReady = 1'b0; InstValid = 1'b1; Inst = 9'b0000_111_11;
        push(4'd0, 3'd7, 3'd3, 5'd3);
        tick();
        Inst = 9'b1111_000_00;
        for (int i = 0; i < 2; i++) begin
            chk("halt_done_low", Done,      0);
            chk("halt_instrdy",  InstReady, 0);
            chk("halt_opvalid",  OpValid,   1);
            tick();
        end
        OpReady = 1'b1;
        tick();
        chk("halt_done",    Done,    1);
        chk("halt_opvalid", OpValid, 0);
        chk("halt_opcount", OpCount, 9);
        Inst = 9'b0000_001_01;
        for (int i = 0; i < 3; i++) begin
            chk("halted_instrdy", InstReady, 0);
            tick();
            chk("halted_opvalid", OpValid, 0);
            chk("halted_done",    Done,    1);
        end
        InstValid = 1'b0;

        // Reset out of HALTED, then reset mid-SWAP
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        #1;
        chk("rst2_done",    Done,      0);
        chk("rst2_opcount", OpCount,   0);
        chk("rst2_illegal", Illegal,   0);
        chk("rst2_instrdy", InstReady, 1);
        InstValid = 1'b1; Inst = 9'b0000_001_01;
        push(4'd0, 3'd1, 3'd1, 5'd1);
        tick();
        Inst = 9'b1010_000_00;
        tick();
        chk("pre_swap_opcount", OpCount, 1);
        chk("pre_swap_illegal", Illegal, 1);
        OpReady = 1'b0; Inst = 9'b1001_010_00;
        tick();
        InstValid = 1'b0;
        chk("swr_opvalid", OpValid,   1);
        chk("swr_instrdy", InstReady, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("swr_rst_opvalid", OpValid,   0);
        chk("swr_rst_opcount", OpCount,   0);
        chk("swr_rst_illegal", Illegal,   0);
        chk("swr_rst_instrdy", InstReady, 0);
        tick();
        Reset_n = 1'b1;
        OpReady = 1'b1; InstValid = 1'b1; Inst = 9'b0000_100_10;
        push(4'd0, 3'd4, 3'd2, 5'd2);
        tick();
        InstValid = 1'b0;
        chk("post_opvalid", OpValid, 1);
        chk("post_dst",     Dst,     4);
        chk("post_src",     Src,     2);
        tick();
        chk("post_opvalid_end", OpValid, 0);
        chk("post_opcount",     OpCount, 1);
        chk("sb_drained",       sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
